// File: rtl/nanci_row_drain.sv
// nanci_row_drain: snapshots one mesh row of PE results and streams the
// {addr,data} words out over valid/ready, PE 0 first, optionally dropping
// MAX_INT padding words.
module nanci_row_drain #(
    parameter int SQRT_N     = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
    parameter bit SKIP_MAX_INT = 1'b1,
    localparam int W  = ADDR_WIDTH + DATA_WIDTH,
    localparam int CW = $clog2(SQRT_N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_done,
    input  logic [SQRT_N*W-1:0] i_row,
    output logic [W-1:0]      o_word,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy,
    output logic [CW-1:0]     o_count
);

    localparam int IW = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       count_q, count_d;
    logic [W-1:0]        buf_q [SQRT_N];
    logic [W-1:0]        buf_d [SQRT_N];
    logic [SQRT_N-1:0]   mask_q, mask_d;
    logic                later_kept;

    // Next-state, capture and output decode; outputs depend only on registered state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        buf_d      = buf_q;
        mask_d     = mask_q;
        o_word     = '0;
        o_valid    = 1'b0;
        o_last     = 1'b0;
        o_busy     = 1'b0;
        later_kept = 1'b0;

        // Any kept word still to come after the current index?
        for (int k = 0; k < SQRT_N; k++) begin
            if (k > int'(idx_q) && mask_q[k]) begin
                later_kept = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_done) begin
                    for (int k = 0; k < SQRT_N; k++) begin
                        buf_d[k]  = i_row[k*W +: W];
                        mask_d[k] = !(SKIP_MAX_INT && (i_row[k*W +: W] == MAX_INT));
                    end
                    idx_d   = '0;
                    count_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                o_busy  = 1'b1;
                o_word  = buf_q[idx_q];
                o_valid = mask_q[idx_q];
                o_last  = mask_q[idx_q] && !later_kept;
                // Advance on a transfer, or straight away past a dropped word.
                if (!mask_q[idx_q] || i_ready) begin
                    if (mask_q[idx_q]) begin
                        count_d = count_q + CW'(1);
                    end
                    if (idx_q == IW'(SQRT_N - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_count = count_q;

    // State register with synchronous reset; reset also abandons any drain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            mask_q  <= '0;
            // NOTE: the capture buffer is a handful of flops, not a RAM, so it
            // is cleared on reset to keep o_word defined from the first cycle.
            for (int k = 0; k < SQRT_N; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            for (int k = 0; k < SQRT_N; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_nanci_row_drain.sv
// Testbench for nanci_row_drain: two instances (padding kept / padding
// dropped) share stimulus; each vector names the instance it checks.
module tb_nanci_row_drain;

    localparam int N  = 4;
    localparam int W  = 6;
    localparam int CW = 3;

    typedef struct {
        bit            sel;      // 0: SKIP_MAX_INT=0 instance, 1: SKIP_MAX_INT=1
        bit            rst;
        bit            done;
        logic [N*W-1:0] row;
        bit            ready;
        logic [W-1:0]  word;
        bit            valid;
        bit            last;
        bit            busy;
        logic [CW-1:0] count;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst, i_done, i_ready;
    logic [N*W-1:0] i_row;
    logic [W-1:0]   word0, word1;
    logic           valid0, valid1, last0, last1, busy0, busy1;
    logic [CW-1:0]  count0, count1;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    nanci_row_drain #(.SQRT_N(N), .ADDR_WIDTH(3), .DATA_WIDTH(3),
                      .MAX_INT(6'b111111), .SKIP_MAX_INT(1'b0)) u_keep (
        .clk(clk), .rst(rst), .i_done(i_done), .i_row(i_row),
        .o_word(word0), .o_valid(valid0), .i_ready(i_ready),
        .o_last(last0), .o_busy(busy0), .o_count(count0));

    nanci_row_drain #(.SQRT_N(N), .ADDR_WIDTH(3), .DATA_WIDTH(3),
                      .MAX_INT(6'b111111), .SKIP_MAX_INT(1'b1)) u_skip (
        .clk(clk), .rst(rst), .i_done(i_done), .i_row(i_row),
        .o_word(word1), .o_valid(valid1), .i_ready(i_ready),
        .o_last(last1), .o_busy(busy1), .o_count(count1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit sel, input bit r, input bit d, input logic [N*W-1:0] row,
                       input bit rdy, input logic [W-1:0] wd, input bit v, input bit l,
                       input bit b, input logic [CW-1:0] c);
        vec_t t;
        t.sel = sel; t.rst = r; t.done = d; t.row = row; t.ready = rdy;
        t.word = wd; t.valid = v; t.last = l; t.busy = b; t.count = c;
        vecs.push_back(t);
    endtask

    task automatic check_dut(input string tag, input bit sel, input logic [W-1:0] wd,
                             input bit v, input bit l, input bit b, input logic [CW-1:0] c);
        check({tag, " word"},  32'(sel ? word1  : word0),  32'(wd));
        check({tag, " valid"}, 32'(sel ? valid1 : valid0), 32'(v));
        check({tag, " last"},  32'(sel ? last1  : last0),  32'(l));
        check({tag, " busy"},  32'(sel ? busy1  : busy0),  32'(b));
        check({tag, " count"}, 32'(sel ? count1 : count0), 32'(c));
    endtask

    initial begin
        logic [N*W-1:0] r1, r2, rs, rp, r3;
        int cycles;
        r1 = {6'd4, 6'd3, 6'd2, 6'd1};
        r2 = {6'd10, 6'd20, 6'd30, 6'd40};
        rs = {6'd63, 6'd7, 6'd63, 6'd5};
        rp = '1;
        r3 = {6'd63, 6'd63, 6'd63, 6'd9};

        //   sel rst done row ready | word valid last busy count
        // Reset state, then full drain without skipping.
        add(0, 0, 0, r1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 1, r1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, r1, 1,  1, 1, 0, 1, 0);
        add(0, 0, 0, r1, 1,  2, 1, 0, 1, 1);
        add(0, 0, 0, r1, 1,  3, 1, 0, 1, 2);
        add(0, 0, 0, r1, 1,  4, 1, 1, 1, 3);
        add(0, 0, 0, r1, 1,  0, 0, 0, 0, 4);
        // Backpressure on word 2 for three cycles.
        add(0, 0, 1, r1, 1,  0, 0, 0, 0, 4);
        add(0, 0, 0, r1, 1,  1, 1, 0, 1, 0);
        add(0, 0, 0, r1, 0,  2, 1, 0, 1, 1);
        add(0, 0, 0, r1, 0,  2, 1, 0, 1, 1);
        add(0, 0, 0, r1, 0,  2, 1, 0, 1, 1);
        add(0, 0, 0, r1, 1,  2, 1, 0, 1, 1);
        add(0, 0, 0, r1, 1,  3, 1, 0, 1, 2);
        add(0, 0, 0, r1, 1,  4, 1, 1, 1, 3);
        add(0, 0, 0, r1, 1,  0, 0, 0, 0, 4);
        // Sentinel skipping: 5, 63, 7, 63.
        add(1, 0, 1, rs, 1,  0, 0, 0, 0, 4);
        add(1, 0, 0, rs, 1,  5, 1, 0, 1, 0);
        add(1, 0, 0, rs, 1, 63, 0, 0, 1, 1);
        add(1, 0, 0, rs, 1,  7, 1, 1, 1, 1);
        add(1, 0, 0, rs, 1, 63, 0, 0, 1, 2);
        add(1, 0, 0, rs, 1,  0, 0, 0, 0, 2);
        // All padding.
        add(1, 0, 1, rp, 1,  0, 0, 0, 0, 2);
        add(1, 0, 0, rp, 1, 63, 0, 0, 1, 0);
        add(1, 0, 0, rp, 1, 63, 0, 0, 1, 0);
        add(1, 0, 0, rp, 1, 63, 0, 0, 1, 0);
        add(1, 0, 0, rp, 1, 63, 0, 0, 1, 0);
        add(1, 0, 0, rp, 1,  0, 0, 0, 0, 0);
        // i_done and new i_row while busy are ignored.
        add(0, 0, 1, r1, 1,  0, 0, 0, 0, 4);
        add(0, 0, 1, r2, 1,  1, 1, 0, 1, 0);
        add(0, 0, 1, r2, 1,  2, 1, 0, 1, 1);
        add(0, 0, 0, r2, 1,  3, 1, 0, 1, 2);
        add(0, 0, 0, r2, 1,  4, 1, 1, 1, 3);
        add(0, 0, 0, r2, 1,  0, 0, 0, 0, 4);
        // Reset after word 2 transfers, then a fresh drain.
        add(0, 0, 1, r2, 1,  0, 0, 0, 0, 4);
        add(0, 0, 0, r2, 1, 40, 1, 0, 1, 0);
        add(0, 0, 0, r2, 1, 30, 1, 0, 1, 1);
        add(0, 1, 0, r2, 1, 20, 1, 0, 1, 2);
        add(0, 0, 0, r2, 1,  0, 0, 0, 0, 0);
        add(0, 0, 1, r1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, r1, 1,  1, 1, 0, 1, 0);
        add(0, 0, 0, r1, 1,  2, 1, 0, 1, 1);
        add(0, 0, 0, r1, 1,  3, 1, 0, 1, 2);
        add(0, 0, 0, r1, 1,  4, 1, 1, 1, 3);
        add(0, 0, 0, r1, 1,  0, 0, 0, 0, 4);

        rst = 1'b1; i_done = 1'b0; i_ready = 1'b1; i_row = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; i_done = vecs[i].done;
            i_row = vecs[i].row; i_ready = vecs[i].ready;
            #1;
            n_vec++;
            check_dut($sformatf("v%0d", i), vecs[i].sel, vecs[i].word, vecs[i].valid,
                      vecs[i].last, vecs[i].busy, vecs[i].count);
        end

        // Reset and i_done in the same cycle: reset wins.
        @(negedge clk);
        rst = 1'b1; i_done = 1'b1; i_row = r1; i_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_done = 1'b0;
        #1;
        n_vec++;
        check_dut("rst_vs_done keep", 0, 0, 0, 0, 0, 0);
        check_dut("rst_vs_done skip", 1, 0, 0, 0, 0, 0);

        // Single kept word followed by padding: last on first word, busy 4 cycles.
        @(negedge clk);
        i_done = 1'b1; i_row = r3;
        @(negedge clk);
        i_done = 1'b0;
        #1;
        n_vec++;
        check_dut("lone_word", 1, 9, 1, 1, 1, 0);
        cycles = 1;
        while (cycles < 10) begin
            @(negedge clk);
            #1;
            if (!busy1) break;
            cycles++;
        end
        n_vec++;
        check("lone_word busy_cycles", 32'(cycles), 32'd4);
        check("lone_word final_count", 32'(count1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/nanci_row_drain.md
# nanci_row_drain

Result-drain block for the Nanci mesh sorter. When a row of `SQRT_N` PEs finishes sorting, it snapshots their `o_PE` buses in one cycle and streams the `{addr,data}` words out one at a time over a valid/ready handshake, leftmost PE (`FIRST_IN_ROW`) first. It is the receiving end of the PE `o_PE` output interface and sits between a mesh row and the result sink (testbench checker or host read-out path). Words equal to `MAX_INT`, the PE padding value, can optionally be dropped.

## Interface
Parameters:
- `SQRT_N`, 4: PEs per row, ≥1.
- `ADDR_WIDTH`, 3: address field width.
- `DATA_WIDTH`, 3: data field width; word width `W = ADDR_WIDTH+DATA_WIDTH`.
- `MAX_INT`, all ones (`W` bits): padding sentinel emitted by empty PEs.
- `SKIP_MAX_INT`, 1: 1 drops words equal to `MAX_INT`; 0 streams every word.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `i_done`  in  1  one-cycle pulse: the row's `o_PE` buses are final.
- `i_row`  in  `SQRT_N*W`  concatenated `o_PE` buses; PE 0 (`FIRST_IN_ROW`) in `[W-1:0]`, PE k in `[k*W +: W]`.
- `o_word`  out  `W`  current word `{addr,data}`.
- `o_valid`  out  1  `o_word` is valid.
- `i_ready`  in  1  sink accepts `o_word` this cycle.
- `o_last`  out  1  qualifies `o_valid`: this is the final word of the drain.
- `o_busy`  out  1  drain in progress; `i_done` is ignored while high.
- `o_count`  out  `$clog2(SQRT_N+1)`  words transferred in the current or most recent drain.

## Operation
- States: IDLE, STREAM.
- IDLE: `o_busy=0`, `o_valid=0`. When `i_done=1` at a clock edge:
  - latch `i_row` into the capture buffer;
  - latch the keep mask (`mask[k] = !(SKIP_MAX_INT && word_k==MAX_INT)`);
  - clear index `idx` and `o_count`;
  - go to STREAM.
- STREAM: `o_word = buf[idx]`, `o_valid = mask[idx]`, `o_last = o_valid && mask[SQRT_N-1:idx+1]==0`.
  - Transfer occurs when `o_valid && i_ready` at an edge. On transfer, `o_count` increments.
  - Each cycle `idx` advances on a transfer, or unconditionally if `mask[idx]=0` (skip, one cycle per dropped word).
  - When `idx == SQRT_N-1` advances, go to IDLE.
  - When `o_valid=1` and `i_ready=0`: hold `idx`; `o_word` and `o_last` stay stable.
- All words masked: STREAM lasts `SQRT_N` cycles with `o_valid` never high; ends with `o_count=0`.
- `i_done` in STREAM: ignored; the buffer is not overwritten.
- `i_row` changes after capture: no effect.
- `o_count` holds its value in IDLE until the next capture clears it.
- `i_ready` high with `o_valid` low: no effect.
- Reset values: state IDLE, `idx=0`, `o_count=0`, buffer and mask cleared.
  - Outputs: `o_word=0`, `o_valid=0`, `o_last=0`, `o_busy=0`.
  - Reset mid-STREAM abandons the drain immediately; no further words are emitted.

## Timing
- Capture at edge E (`i_done` high). The first word's `o_valid` is visible in the cycle after E (latency 1), with no leading skips.
- Each leading masked word adds one cycle.
- Throughput is one word per cycle while `i_ready=1`.
- `o_valid`, `o_word`, and `o_last` are decoded only from registered state; there is no combinational path from `i_ready` or `i_row`.
- `o_busy` rises the cycle after E and falls the cycle after the final transfer or skip.
- Minimum drain length: `SQRT_N` cycles; the next `i_done` is accepted in the first IDLE cycle.
- `i_done` in the same cycle `rst` is high: reset wins.

## Test plan
All scenarios use `SQRT_N=4`, `ADDR_WIDTH=3`, `DATA_WIDTH=3`, `MAX_INT=6'b111111`.
- **Full drain, no skipping:** `SKIP_MAX_INT=0`, `i_row={4,3,2,1}` (PE0=1), `i_ready=1`, pulse `i_done` → words 1,2,3,4 on four consecutive cycles starting the cycle after the pulse; `o_last` only with 4; `o_count=4`; `o_busy` low after.
- **Backpressure:** same data, `i_ready` low for 3 cycles while word 2 is presented → `o_word=2` and `o_valid=1` held stable; order 1,2,3,4 preserved; no duplicates.
- **Sentinel skipping:** `SKIP_MAX_INT=1`, PE0..3 = 5, 63, 7, 63 → emits 5 then 7 (one gap cycle between them); `o_last` with 7; `o_count=2`; drain takes 4 cycles.
- **All padding:** `SKIP_MAX_INT=1`, all PEs = 63 → `o_valid` never asserts; `o_busy` high exactly 4 cycles; `o_count=0`.
- **`i_done` while busy:** second `i_done` pulse during STREAM with different `i_row` → ignored; original words delivered.
- **Reset mid-stream:** `rst` after word 2 is transferred → next cycle all outputs 0; a subsequent `i_done` drains a fresh snapshot correctly.
